// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the alignment rule applied to incoming requests.
package dmem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        ERR
    } state_e;

    // Illegal size codes are reported through the same error path as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated write data for stores,
// lane extraction with sign/zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              unsigned_ld,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wlane,
    output logic [DATA_W-1:0] ldata
);

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;

    assign byte_sh = rword >> {offset, 3'b000};
    assign half_sh = rword >> {offset[1], 4'b0000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        be    = 4'b0000;
        wlane = wdata;
        ldata = rword;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << offset;
                wlane = {4{wdata[7:0]}};
                ldata = unsigned_ld ? {24'h0, byte_sh[7:0]}
                                    : {{24{byte_sh[7]}}, byte_sh[7:0]};
            end
            SZ_HALF: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                ldata = unsigned_ld ? {16'h0, half_sh[15:0]}
                                    : {{16{half_sh[15]}}, half_sh[15:0]};
            end
            SZ_WORD: begin
                be = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the load/store path: one request at a time, optional
// wait latency, byte/half/word access into an internal little-endian RAM.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              load_wb,
    output logic              misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state;
    state_e            state_next;
    logic [CW-1:0]     cnt;
    logic              lat_we;
    logic              lat_uns;
    logic [1:0]        lat_size;
    logic [AW+1:0]     lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]     widx;
    logic [3:0]        be;
    logic [DATA_W-1:0] wlane;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] ldata;
    logic              accept;
    logic              bad_req;
    logic              addr_hi_unused;

    // Bits above the array span are dropped so accesses wrap around the RAM.
    assign addr_hi_unused = ^addr[31:AW+2];

    assign accept  = (state == IDLE) && req;
    assign bad_req = is_misaligned(size, addr[1:0]);
    assign widx    = lat_addr[AW+1:2];
    assign rword   = mem[widx];
    assign busy    = (state == WAIT) || (state == ACCESS);

    dmem_lane_align u_align (
        .size        (lat_size),
        .offset      (lat_addr[1:0]),
        .unsigned_ld (lat_uns),
        .wdata       (lat_wdata),
        .rword       (rword),
        .be          (be),
        .wlane       (wlane),
        .ldata       (ldata)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_req)           state_next = ERR;
                    else if (LATENCY == 0) state_next = ACCESS;
                    else                   state_next = WAIT;
                end
            end
            WAIT:    if (cnt == '0) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= CW'(LATENCY - 1);
            lat_we    <= we;
            lat_uns   <= unsigned_ld;
            lat_size  <= size;
            lat_addr  <= addr[AW+1:0];
            lat_wdata <= wdata;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // NOTE: the RAM array is deliberately left out of reset; only the write is gated by it.
    always_ff @(posedge clk) begin
        if (reset && state == ACCESS && lat_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            done     <= 1'b0;
            load_wb  <= 1'b0;
            misalign <= 1'b0;
            rdata    <= '0;
        end else begin
            done     <= 1'b0;
            load_wb  <= 1'b0;
            misalign <= 1'b0;
            if (state == ACCESS) begin
                done    <= 1'b1;
                load_wb <= !lat_we;
                if (!lat_we) rdata <= ldata;
            end else if (accept && bad_req) begin
                done     <= 1'b1;
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model predicts each
// completion, and a monitor compares whenever the DUT pulses done.
module tb_data_mem_ctrl;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;
    localparam int NBYTES      = DEPTH_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        load_wb;
    logic        misalign;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        load_wb;
        logic        misalign;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] last_rdata;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .load_wb     (load_wb),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int base = int'(a % NBYTES);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[base + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        int          base = int'(a % NBYTES);
        int          n    = nbytes(sz);
        logic [31:0] v    = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (n < 4 && !uns && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // ---------------- driver ----------------
    // Holds the request one cycle, then idles (or spams junk requests) until the
    // cycle in which the response is due, where the next request may be presented.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input bit spam);
        exp_t e;
        bit   bad;
        int   waitn;
        bad = is_bad(sz, a);
        if (!bad) begin
            if (w) model_store(a, sz, d);
            else   last_rdata = model_load(a, sz, uns);
        end
        e.cyc      = cyc + (bad ? 1 : LATENCY + 2);
        e.rdata    = last_rdata;
        e.load_wb  = !bad && !w;
        e.misalign = bad;
        sbq.push_back(e);

        req = 1'b1; we = w; size = sz; unsigned_ld = uns; addr = a; wdata = d;
        waitn = bad ? 2 : LATENCY + 2;
        for (int i = 1; i < waitn; i++) begin
            @(negedge clk);
            if (i == 1) check("busy_after_accept", {31'h0, busy}, {31'h0, !bad});
            if (spam) begin
                req = 1'b1; we = 1'($urandom); size = 2'($urandom);
                unsigned_ld = 1'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (done) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no response (cycle %0d)", cyc);
                    end else begin
                        e = sbq.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("rdata", rdata, e.rdata);
                        check("load_wb", {31'h0, load_wb}, {31'h0, e.load_wb});
                        check("misalign", {31'h0, misalign}, {31'h0, e.misalign});
                        check("busy_in_done", {31'h0, busy}, 32'h0);
                    end
                end else if (load_wb || misalign) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_without_done: got load_wb=%0b misalign=%0b expected 0 (cycle %0d)",
                             load_wb, misalign, cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0; last_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_load_wb", {31'h0, load_wb}, 32'h0);
        check("reset_misalign", {31'h0, misalign}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        reset = 1'b1;

        // Give every RAM word a known value so all later loads are predictable.
        for (int w = 0; w < DEPTH_WORDS; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0);

        // Word store/load, byte store with signed/unsigned/word readback.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

        // Misaligned half load, then confirm memory untouched.
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

        // Requests hammered while busy must be dropped.
        issue(1'b1, 2'b10, 1'b0, 32'h44, 32'h1122_3344, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h48, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h46, 32'h0, 1'b0);

        // Reset during WAIT aborts a store before it reaches the array.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        req = 1'b1; we = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
        addr = 32'h20; wdata = 32'h1234_5678;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_load_wb", {31'h0, load_wb}, 32'h0);
        check("abort_misalign", {31'h0, misalign}, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        last_rdata = 32'h0;
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // Address wrap: 0x400 aliases word 0.
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0);

        // Randomized mix of sizes, alignments, signedness and busy-time spam.
        for (int k = 0; k < 300; k++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01)      a[0]   = 1'b0;
                else if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
